// File: rtl/chess_clock_pkg.sv
// Shared types and helpers for the chess clock: FSM states, player encoding,
// and a width-generic saturating add.
package chess_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_WHITE,
    ST_RUN_BLACK,
    ST_PAUSED,
    ST_TIMEOUT
  } state_e;

  localparam logic PLAYER_WHITE = 1'b0;
  localparam logic PLAYER_BLACK = 1'b1;

  // a + b clamped to 2**w-1; the sum is formed one bit wider so it cannot wrap.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/chess_tick_gen.sv
// Prescaler producing a one-second strobe. 'term' is the same-cycle wrap strobe
// used by the FSM; 'tick' is its registered copy for the outside world.
module chess_tick_gen #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic term,
  output logic tick
);

  localparam int unsigned PRE_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PRE_W-1:0] LAST = PRE_W'(CLK_FREQ - 1);

  logic [PRE_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    term   = enable && (cnt_q == LAST);
    tick_d = term;
    cnt_d  = cnt_q;
    if (clear || term) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/chess_clock_controller.sv
// Two-player chess clock: turn FSM, per-player seconds budgets with optional
// Fischer increment, sticky timeout flags and a 1 Hz tick from chess_tick_gen.
module chess_clock_controller
  import chess_clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned TIME_W     = 12,
  parameter int unsigned START_TIME = 600,
  parameter int unsigned INCREMENT  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              start,
  input  logic              move_done,
  input  logic              pause_toggle,
  output logic [TIME_W-1:0] white_time,
  output logic [TIME_W-1:0] black_time,
  output logic              active_player,
  output logic              running,
  output logic              white_flag,
  output logic              black_flag,
  output logic              tick
);

  localparam logic [TIME_W-1:0] START_VAL = TIME_W'(START_TIME);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] white_q, white_d, black_q, black_d;
  logic              active_q, active_d;
  logic              running_q, running_d;
  logic              wflag_q, wflag_d, bflag_q, bflag_d;

  logic              is_run, pre_clr, pre_en, term;
  logic [TIME_W-1:0] mover_time, dec_time, upd_time;
  logic              upd_en;

  chess_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .clear  (pre_clr),
    .enable (pre_en),
    .term   (term),
    .tick   (tick)
  );

  // The prescaler only advances on cycles that both start and end in a run
  // state, so a pause freezes it at the exact count it had reached.
  assign is_run     = (state_q == ST_RUN_WHITE) || (state_q == ST_RUN_BLACK);
  assign pre_en     = is_run && !load && !(pause_toggle && !move_done);
  assign mover_time = active_q ? black_q : white_q;
  assign dec_time   = term ? (mover_time - 1'b1) : mover_time;

  always_comb begin
    state_d  = state_q;
    white_d  = white_q;
    black_d  = black_q;
    active_d = active_q;
    wflag_d  = wflag_q;
    bflag_d  = bflag_q;
    pre_clr  = 1'b0;
    upd_en   = 1'b0;
    upd_time = dec_time;
    if (load) begin
      state_d  = ST_IDLE;
      white_d  = START_VAL;
      black_d  = START_VAL;
      active_d = PLAYER_WHITE;
      wflag_d  = 1'b0;
      bflag_d  = 1'b0;
      pre_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_RUN_WHITE;
            active_d = PLAYER_WHITE;
            pre_clr  = 1'b1;
          end
        end
        ST_RUN_WHITE, ST_RUN_BLACK: begin
          if (term && (mover_time == TIME_W'(1))) begin
            upd_en  = 1'b1;
            state_d = ST_TIMEOUT;
            if (active_q) bflag_d = 1'b1;
            else          wflag_d = 1'b1;
          end else if (move_done) begin
            upd_en   = 1'b1;
            upd_time = TIME_W'(sat_add(32'(dec_time), 32'(INCREMENT), TIME_W));
            active_d = ~active_q;
            state_d  = active_q ? ST_RUN_WHITE : ST_RUN_BLACK;
            pre_clr  = 1'b1;
          end else if (pause_toggle) begin
            state_d = ST_PAUSED;
          end else begin
            upd_en = term;
          end
        end
        ST_PAUSED: begin
          if (pause_toggle) state_d = active_q ? ST_RUN_BLACK : ST_RUN_WHITE;
        end
        default: ;
      endcase
    end
    if (upd_en) begin
      if (active_q) black_d = upd_time;
      else          white_d = upd_time;
    end
    running_d = (state_d == ST_RUN_WHITE) || (state_d == ST_RUN_BLACK);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      white_q   <= START_VAL;
      black_q   <= START_VAL;
      active_q  <= PLAYER_WHITE;
      running_q <= 1'b0;
      wflag_q   <= 1'b0;
      bflag_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      white_q   <= white_d;
      black_q   <= black_d;
      active_q  <= active_d;
      running_q <= running_d;
      wflag_q   <= wflag_d;
      bflag_q   <= bflag_d;
    end
  end

  assign white_time    = white_q;
  assign black_time    = black_q;
  assign active_player = active_q;
  assign running       = running_q;
  assign white_flag    = wflag_q;
  assign black_flag    = bflag_q;

endmodule

// File: tb/tb_chess_clock_controller.sv
// Directed scenarios plus random pulse traffic, checked against a game-level
// model of the chess clock and against hand-derived constants.
module tb_chess_clock_controller;

  localparam int CLK_FREQ   = 4;
  localparam int TIME_W     = 4;
  localparam int START_TIME = 3;
  localparam int INCREMENT  = 2;
  localparam int TMAX       = (1 << TIME_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              load = 1'b0, start = 1'b0, move_done = 1'b0, pause_toggle = 1'b0;
  logic [TIME_W-1:0] white_time, black_time;
  logic              active_player, running, white_flag, black_flag, tick;

  int checks = 0;
  int errors = 0;

  chess_clock_controller #(
    .CLK_FREQ   (CLK_FREQ),
    .TIME_W     (TIME_W),
    .START_TIME (START_TIME),
    .INCREMENT  (INCREMENT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .load          (load),
    .start         (start),
    .move_done     (move_done),
    .pause_toggle  (pause_toggle),
    .white_time    (white_time),
    .black_time    (black_time),
    .active_player (active_player),
    .running       (running),
    .white_flag    (white_flag),
    .black_flag    (black_flag),
    .tick          (tick)
  );

  always #5 clock = ~clock;

  // Game-level model: who is on move, whether the game has begun, is paused
  // or is over, and how many cycles of the current second have elapsed.
  int m_time[2];
  bit m_flag[2];
  bit m_started, m_paused, m_over, m_active, m_tick;
  int m_phase;

  task automatic model_reset();
    m_time[0] = START_TIME; m_time[1] = START_TIME;
    m_flag[0] = 0; m_flag[1] = 0;
    m_started = 0; m_paused = 0; m_over = 0; m_active = 0; m_tick = 0;
    m_phase = 0;
  endtask

  task automatic model_step(input bit ld, input bit st, input bit mv, input bit pz);
    int  t;
    bit  counting;
    m_tick = 0;
    if (ld) begin
      model_reset();
    end else if (!m_started || m_over) begin
      if (!m_started && !m_over && st) begin
        m_started = 1; m_active = 0; m_phase = 0;
      end
    end else if (m_paused) begin
      if (pz) m_paused = 0;
    end else begin
      counting = !(pz && !mv);
      m_tick = counting && (m_phase == CLK_FREQ - 1);
      if (counting) m_phase = (m_phase + 1) % CLK_FREQ;
      t = m_time[m_active] - (m_tick ? 1 : 0);
      if (m_tick && t == 0) begin
        m_time[m_active] = 0; m_flag[m_active] = 1; m_over = 1;
      end else if (mv) begin
        m_time[m_active] = (t + INCREMENT > TMAX) ? TMAX : t + INCREMENT;
        m_active = !m_active; m_phase = 0;
      end else if (pz) begin
        m_paused = 1;
      end else begin
        m_time[m_active] = t;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("white_time", 32'(white_time), m_time[0]);
    chk("black_time", 32'(black_time), m_time[1]);
    chk("active_player", 32'(active_player), 32'(m_active));
    chk("running", 32'(running), 32'(m_started && !m_paused && !m_over));
    chk("white_flag", 32'(white_flag), 32'(m_flag[0]));
    chk("black_flag", 32'(black_flag), 32'(m_flag[1]));
    chk("tick", 32'(tick), 32'(m_tick));
  endtask

  task automatic cycle(input bit ld, input bit st, input bit mv, input bit pz);
    load = ld; start = st; move_done = mv; pause_toggle = pz;
    model_step(ld, st, mv, pz);
    @(posedge clock);
    #1;
    load = 0; start = 0; move_done = 0; pause_toggle = 0;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_white"}, 32'(white_time), START_TIME);
    chk({tag, "_black"}, 32'(black_time), START_TIME);
    chk({tag, "_active"}, 32'(active_player), 0);
    chk({tag, "_running"}, 32'(running), 0);
    chk({tag, "_flags"}, 32'({white_flag, black_flag}), 0);
    chk({tag, "_tick"}, 32'(tick), 0);
  endtask

  initial begin
    model_reset();
    #12;
    chk_reset_vals("reset");
    @(negedge clock);
    reset = 1'b1;

    // 1: first second of white's turn
    cycle(0, 1, 0, 0);
    chk("t1_running", 32'(running), 1);
    chk("t1_active", 32'(active_player), 0);
    idle(3);
    chk("t1_no_tick_early", 32'(tick), 0);
    idle(1);
    chk("t1_tick", 32'(tick), 1);
    chk("t1_white", 32'(white_time), 2);
    chk("t1_black", 32'(black_time), 3);

    // 2: move with increment, black's second starts fresh
    cycle(0, 0, 1, 0);
    chk("t2_white", 32'(white_time), 4);
    chk("t2_active", 32'(active_player), 1);
    idle(3);
    chk("t2_black_hold", 32'(black_time), 3);
    idle(1);
    chk("t2_black_dec", 32'(black_time), 2);

    // 3: white runs out of time; TIMEOUT sticks until load
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    idle(4);  chk("t3_w2", 32'(white_time), 2);
    idle(4);  chk("t3_w1", 32'(white_time), 1);
    idle(4);  chk("t3_w0", 32'(white_time), 0);
    chk("t3_flag", 32'(white_flag), 1);
    chk("t3_running", 32'(running), 0);
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    idle(5);
    chk("t3_hold_white", 32'(white_time), 0);
    chk("t3_hold_active", 32'(active_player), 0);
    chk("t3_hold_running", 32'(running), 0);
    cycle(1, 0, 0, 0);
    chk_reset_vals("t3_load");

    // 4: pause freezes the prescaler at its count
    cycle(0, 1, 0, 0);
    idle(2);
    cycle(0, 0, 0, 1);
    idle(20);
    chk("t4_frozen_white", 32'(white_time), 3);
    chk("t4_frozen_running", 32'(running), 0);
    cycle(0, 0, 0, 1);
    chk("t4_resumed", 32'(running), 1);
    idle(1);
    chk("t4_tick_wait", 32'(tick), 0);
    idle(1);
    chk("t4_tick", 32'(tick), 1);
    chk("t4_white", 32'(white_time), 2);

    // 5a: tick + move at white_time=2
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    idle(4);
    idle(3);
    cycle(0, 0, 1, 0);
    chk("t5a_white", 32'(white_time), 3);
    chk("t5a_active", 32'(active_player), 1);
    chk("t5a_tick", 32'(tick), 1);

    // 5b: tick + move at white_time=1 times out, no switch
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    idle(8);
    idle(3);
    cycle(0, 0, 1, 0);
    chk("t5b_white", 32'(white_time), 0);
    chk("t5b_flag", 32'(white_flag), 1);
    chk("t5b_active", 32'(active_player), 0);
    chk("t5b_running", 32'(running), 0);

    // 5c: increments saturate at 15
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    idle(4);
    repeat (13) cycle(0, 0, 1, 0);
    chk("t5c_white_sat", 32'(white_time), 15);
    chk("t5c_black", 32'(black_time), 15);

    // 6: asynchronous reset in RUN_BLACK, then load beats move
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    idle(1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    chk_reset_vals("t6_load_move");

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(63) == 0, $urandom_range(7) == 0,
            $urandom_range(5) == 0, $urandom_range(9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
